// File: rtl/instr_issue.sv
// Instruction fetch/issue sequencer: fetches one word, then presents it to the decoder
// for an opcode-dependent number of non-stalled cycles. Optional HALT via INSTR_ISSUE_HALT_EN.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_FETCH | raise imem_rd_en for one cycle with imem_addr = pc
// S_WAIT  | wait for imem_valid, latch the word, load the hold counter
// S_ISSUE | instr_valid high; counter runs down on non-stalled cycles
// S_HALT  | HLT opcode seen; parked until reset (INSTR_ISSUE_HALT_EN only)

module instr_issue (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_rd_en,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_valid,
    input  logic        stall,
    output logic [15:0] instr,
    output logic        instr_valid,
    output logic [15:0] pc,
    output logic        busy,
    output logic        halted
);

    localparam logic [15:0] NOP_WORD = 16'hF000;
    localparam logic [3:0]  OP_VLD   = 4'b0100;
    localparam logic [3:0]  OP_VST   = 4'b0101;
    localparam logic [3:0]  OP_HLT   = 4'b1110;

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_ISSUE
`ifdef INSTR_ISSUE_HALT_EN
        , S_HALT
`endif
    } state_t;

    state_t     state;
    logic [4:0] hold_cnt;

    function automatic logic [4:0] hold_count(input logic [3:0] op);
        case (op)
            OP_VLD:  hold_count = 5'd16;
            OP_VST:  hold_count = 5'd15;
            default: hold_count = 5'd1;
        endcase
    endfunction

    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_FETCH;
            pc          <= 16'h0000;
            instr       <= NOP_WORD;
            hold_cnt    <= 5'd0;
            instr_valid <= 1'b0;
            imem_rd_en  <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
        end else begin
            imem_rd_en <= 1'b0;
            case (state)
                // First FETCH cycle after reset only arms the request; the
                // ISSUE exit arms it directly so back-to-back fetches take one cycle.
                S_FETCH: begin
                    if (!imem_rd_en) begin
                        imem_rd_en <= 1'b1;
                    end else begin
                        state <= S_WAIT;
                        busy  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_valid) begin
`ifdef INSTR_ISSUE_HALT_EN
                        if (imem_rdata[15:12] == OP_HLT) begin
                            state  <= S_HALT;
                            instr  <= NOP_WORD;
                            busy   <= 1'b0;
                            halted <= 1'b1;
                        end else begin
                            state       <= S_ISSUE;
                            instr       <= imem_rdata;
                            hold_cnt    <= hold_count(imem_rdata[15:12]);
                            pc          <= pc + 16'd1;
                            instr_valid <= 1'b1;
                        end
`else
                        state       <= S_ISSUE;
                        instr       <= imem_rdata;
                        hold_cnt    <= hold_count(imem_rdata[15:12]);
                        pc          <= pc + 16'd1;
                        instr_valid <= 1'b1;
`endif
                    end
                end
                S_ISSUE: begin
                    if (!stall) begin
                        if (hold_cnt <= 5'd1) begin
                            state       <= S_FETCH;
                            hold_cnt    <= 5'd0;
                            instr_valid <= 1'b0;
                            busy        <= 1'b0;
                            imem_rd_en  <= 1'b1;
                        end else begin
                            hold_cnt <= hold_cnt - 5'd1;
                        end
                    end
                end
`ifdef INSTR_ISSUE_HALT_EN
                S_HALT: begin
                    halted <= 1'b1;
                end
`endif
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_issue.sv
// Directed bench for instr_issue: behavioural instruction memory with programmable
// latency, stall injection, reset abort and the optional HALT opcode.
module tb_instr_issue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_rd_en;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid;
    logic        stall;
    logic [15:0] instr;
    logic        instr_valid;
    logic [15:0] pc;
    logic        busy;
    logic        halted;

    always #5 clk = ~clk;

    instr_issue dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_rd_en (imem_rd_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_valid (imem_valid),
        .stall      (stall),
        .instr      (instr),
        .instr_valid(instr_valid),
        .pc         (pc),
        .busy       (busy),
        .halted     (halted)
    );

    logic [15:0] mem [0:255];
    int          lat = 1;
    bit          spur_en = 1'b0;
    logic [7:0]  mem_a;
    int          mem_k;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Memory: answers a request 'lat' cycles later; a reset drops the pending answer.
    initial begin
        imem_valid = 1'b0;
        imem_rdata = 16'hDEAD;
        forever begin
            @(posedge clk); #1;
            if (imem_rd_en && rst_n) begin
                mem_a = imem_addr[7:0];
                mem_k = 0;
                while (mem_k < lat && rst_n) begin
                    @(posedge clk);
                    mem_k++;
                end
                if (rst_n) begin
                    #1;
                    imem_rdata = mem[mem_a];
                    imem_valid = 1'b1;
                    @(posedge clk); #1;
                    imem_valid = 1'b0;
                    imem_rdata = 16'hDEAD;
                    if (spur_en) begin
                        spur_en = 1'b0;
                        @(posedge clk);
                        @(posedge clk); #1;
                        imem_rdata = 16'hBEEF;
                        imem_valid = 1'b1;
                        @(posedge clk); #1;
                        imem_valid = 1'b0;
                        imem_rdata = 16'hDEAD;
                    end
                end
            end
        end
    end

    // Waits for an issue window and measures it; stall is driven for st_len
    // cycles starting at the st_at-th valid cycle. Returns at the first idle negedge.
    task automatic window(input int st_at, input int st_len, output int n,
                          output logic [15:0] first, output bit stable);
        int t;
        n = 0;
        t = 0;
        stable = 1'b1;
        while (!instr_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        first = instr;
        while (instr_valid && n < 100) begin
            if (instr !== first) stable = 1'b0;
            n++;
            stall = (n >= st_at && n < st_at + st_len);
            @(negedge clk);
        end
        stall = 1'b0;
    endtask

    int          n;
    logic [15:0] first;
    bit          stable;
    int          rd_seen;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        stall = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
        mem[0] = 16'h0AC8;
        mem[1] = 16'h4A45;
        mem[2] = 16'h5A45;
        mem[3] = 16'h4A45;
        mem[4] = 16'h4A45;
        mem[5] = 16'h4A45;
        mem[6] = 16'h0777;
        repeat (3) @(negedge clk);

        check("rst_rd_en",  {31'd0, imem_rd_en}, 32'd0);
        check("rst_valid",  {31'd0, instr_valid}, 32'd0);
        check("rst_instr",  {16'd0, instr}, 32'h0000F000);
        check("rst_pc",     {16'd0, pc}, 32'd0);
        check("rst_busy",   {31'd0, busy}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("fetch0_rd_en", {31'd0, imem_rd_en}, 32'd1);
        check("fetch0_addr",  {16'd0, imem_addr}, 32'd0);

        window(1000, 0, n, first, stable);
        check("vadd_len",   n, 32'd1);
        check("vadd_instr", {16'd0, first}, 32'h00000AC8);
        check("vadd_pc",    {16'd0, pc}, 32'd1);
        check("fetch1_rd_en", {31'd0, imem_rd_en}, 32'd1);
        check("fetch1_addr",  {16'd0, imem_addr}, 32'd1);
        stall = 1'b1;
        @(negedge clk);
        check("wait_busy",  {31'd0, busy}, 32'd1);
        check("wait_rd_en", {31'd0, imem_rd_en}, 32'd0);

        window(1000, 0, n, first, stable);
        check("vld_len",    n, 32'd16);
        check("vld_instr",  {16'd0, first}, 32'h00004A45);
        check("vld_stable", {31'd0, stable}, 32'd1);
        check("vld_pc",     {16'd0, pc}, 32'd2);
        window(1000, 0, n, first, stable);
        check("vst_len",    n, 32'd15);
        check("vst_instr",  {16'd0, first}, 32'h00005A45);
        window(5, 3, n, first, stable);
        check("stall_len",    n, 32'd19);
        check("stall_stable", {31'd0, stable}, 32'd1);
        window(16, 2, n, first, stable);
        check("stall_last_len", n, 32'd18);

        lat = 4;
        spur_en = 1'b1;
        window(1000, 0, n, first, stable);
        check("spur_len",    n, 32'd16);
        check("spur_instr",  {16'd0, first}, 32'h00004A45);
        check("spur_stable", {31'd0, stable}, 32'd1);
        check("spur_pc",     {16'd0, pc}, 32'd6);
        force dut.pc = 16'hFFFF;
        @(negedge clk);
        release dut.pc;
        window(1000, 0, n, first, stable);
        check("lat4_len",   n, 32'd1);
        check("lat4_instr", {16'd0, first}, 32'h00000777);
        check("wrap_pc",    {16'd0, pc}, 32'd0);
        check("wrap_addr",  {16'd0, imem_addr}, 32'd0);

        lat = 1;
        mem[0] = 16'h4A45;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (n < 200 && !instr_valid) begin
            @(negedge clk);
            n++;
        end
        repeat (7) @(negedge clk);
        check("mid_valid", {31'd0, instr_valid}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_valid", {31'd0, instr_valid}, 32'd0);
        check("abort_instr", {16'd0, instr}, 32'h0000F000);
        check("abort_pc",    {16'd0, pc}, 32'd0);
        check("abort_busy",  {31'd0, busy}, 32'd0);
        check("abort_rd_en", {31'd0, imem_rd_en}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("restart_rd_en", {31'd0, imem_rd_en}, 32'd1);
        check("restart_addr",  {16'd0, imem_addr}, 32'd0);

        mem[0] = 16'h0AC8;
        mem[1] = 16'h0AC8;
        mem[2] = 16'hE000;
        mem[3] = 16'h0AC8;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        window(1000, 0, n, first, stable);
        check("prog0_len", n, 32'd1);
        window(1000, 0, n, first, stable);
        check("prog1_len", n, 32'd1);
`ifdef INSTR_ISSUE_HALT_EN
        repeat (2) @(negedge clk);
        check("hlt_halted", {31'd0, halted}, 32'd1);
        check("hlt_pc",     {16'd0, pc}, 32'd2);
        check("hlt_instr",  {16'd0, instr}, 32'h0000F000);
        check("hlt_valid",  {31'd0, instr_valid}, 32'd0);
        check("hlt_busy",   {31'd0, busy}, 32'd0);
        rd_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (imem_rd_en) rd_seen++;
        end
        check("hlt_no_fetch", rd_seen, 32'd0);
        check("hlt_stays",    {31'd0, halted}, 32'd1);
`else
        window(1000, 0, n, first, stable);
        check("hlt_len",    n, 32'd1);
        check("hlt_instr",  {16'd0, first}, 32'h0000E000);
        check("hlt_pc",     {16'd0, pc}, 32'd3);
        check("hlt_halted", {31'd0, halted}, 32'd0);
        rd_seen = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
